// File: rtl/impl_stim_gen_if.sv
// Config/stimulus bundle between a driver and impl_stim_gen.
// Latency: none; this is wiring only.
// Backpressure: none; start is sampled by the generator only while it is idle.
interface impl_stim_gen_if #(
    parameter int DELAY_W = 3,
    parameter int CNT_W   = 8
);
    logic               start;
    logic [CNT_W-1:0]   num_txn;
    logic [DELAY_W-1:0] delay;
    logic [3:0]         gap;
    logic [3:0]         inject_every;
    logic               a;
    logic               b;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   txn_cnt;
    logic [CNT_W-1:0]   err_cnt;

    // Driver side: supplies the run configuration and observes the stimulus.
    modport master (
        output start, num_txn, delay, gap, inject_every,
        input  a, b, busy, done, txn_cnt, err_cnt
    );

    // Generator side.
    modport slave (
        input  start, num_txn, delay, gap, inject_every,
        output a, b, busy, done, txn_cnt, err_cnt
    );
endinterface

// File: rtl/impl_stim_gen.sv
// Antecedent/consequent generator: b follows each a pulse after a latched delay, with optional drops.
// Latency: first a one cycle after start is accepted; each transaction lasts 1+delay+gap cycles.
// Backpressure: start is ignored while busy (including the done cycle); outputs decode registered state only.
module impl_stim_gen #(
    parameter int DELAY_W = 3,
    parameter int CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    impl_stim_gen_if.slave sif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ANTE,
        S_WAIT,
        S_CONS,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_n;

    logic [CNT_W-1:0]   num_q;
    logic [DELAY_W-1:0] delay_q;
    logic [3:0]         gap_q;
    logic [3:0]         inj_q;

    logic [CNT_W-1:0]   txn_cnt;
    logic [CNT_W-1:0]   err_cnt;
    logic [3:0]         mod_cnt;   // antecedents since the last drop
    logic               drop_q;    // current transaction's consequent is suppressed
    logic [DELAY_W-1:0] wait_cnt;
    logic [3:0]         gap_cnt;

    logic               drop_now;
    logic [CNT_W-1:0]   txn_inc;
    logic               more_after_ante;
    logic               more;

    // Drop decision for the antecedent in flight; txn_cnt has not yet advanced in ANTE,
    // so the "more transactions" test there uses the incremented value.
    always_comb begin
        drop_now        = (inj_q != 4'd0) && (mod_cnt == inj_q - 4'd1);
        txn_inc         = txn_cnt + CNT_W'(1);
        more_after_ante = (txn_inc < num_q);
        more            = (txn_cnt < num_q);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        state_n      = state;
        sif.a        = 1'b0;
        sif.b        = 1'b0;
        sif.busy     = (state != S_IDLE);
        sif.done     = 1'b0;
        sif.txn_cnt  = txn_cnt;
        sif.err_cnt  = err_cnt;
        case (state)
            S_IDLE: begin
                if (sif.start) begin
                    state_n = (sif.num_txn == '0) ? S_DONE : S_ANTE;
                end
            end
            S_ANTE: begin
                sif.a = 1'b1;
                sif.b = (delay_q == '0) && !drop_now;
                if (delay_q == '0) begin
                    if (gap_q != 4'd0)        state_n = S_GAP;
                    else if (more_after_ante) state_n = S_ANTE;
                    else                      state_n = S_DONE;
                end else if (delay_q == DELAY_W'(1)) begin
                    state_n = S_CONS;
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == '0) state_n = S_CONS;
            end
            S_CONS: begin
                sif.b = !drop_q;
                if (gap_q != 4'd0) state_n = S_GAP;
                else if (more)     state_n = S_ANTE;
                else               state_n = S_DONE;
            end
            S_GAP: begin
                if (gap_cnt == 4'd0) state_n = more ? S_ANTE : S_DONE;
            end
            S_DONE: begin
                sif.done = 1'b1;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Config latch, transaction/drop counters and delay/gap down-counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q    <= '0;
            delay_q  <= '0;
            gap_q    <= '0;
            inj_q    <= '0;
            txn_cnt  <= '0;
            err_cnt  <= '0;
            mod_cnt  <= '0;
            drop_q   <= 1'b0;
            wait_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sif.start) begin
                        num_q   <= sif.num_txn;
                        delay_q <= sif.delay;
                        gap_q   <= sif.gap;
                        inj_q   <= sif.inject_every;
                        txn_cnt <= '0;
                        err_cnt <= '0;
                        mod_cnt <= '0;
                        drop_q  <= 1'b0;
                    end
                end
                S_ANTE: begin
                    txn_cnt  <= txn_inc;
                    drop_q   <= drop_now;
                    // WAIT spans delay-1 cycles, so the counter starts at delay-2.
                    wait_cnt <= delay_q - DELAY_W'(2);
                    if (inj_q != 4'd0) begin
                        mod_cnt <= drop_now ? 4'd0 : mod_cnt + 4'd1;
                    end
                    // With zero delay the consequent cycle is this one.
                    if ((delay_q == '0) && drop_now) begin
                        err_cnt <= err_cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - DELAY_W'(1);
                end
                S_CONS: begin
                    if (drop_q) err_cnt <= err_cnt + CNT_W'(1);
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt - 4'd1;
                end
                default: ;
            endcase
            // Load the gap counter on entry so GAP lasts exactly gap cycles.
            if ((state_n == S_GAP) && (state != S_GAP)) begin
                gap_cnt <= gap_q - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_impl_stim_gen.sv
// Directed bench for impl_stim_gen: table of run configurations plus start-ignore and reset-abort sequences.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_impl_stim_gen;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    impl_stim_gen_if #(.DELAY_W(3), .CNT_W(8)) sif ();

    impl_stim_gen #(.DELAY_W(3), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          num;
        int          dly;
        int          gap;
        int          inj;
        logic [63:0] a_m;
        logic [63:0] b_m;
        int          done_c;
        int          txn;
        int          err;
    } vec_t;

    vec_t vt[7];

    function automatic logic [63:0] bm(input int c);
        logic [63:0] one;
        one = 64'd1;
        return one << c;
    endfunction

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m |= bm(i);
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle 0 is the cycle where start is first sampled; outputs of cycle c are
    // sampled at its falling edge, then the inputs for cycle c are applied.
    task automatic run(input int num, input int dly, input int gp, input int inj,
                       input int ncyc, input logic [63:0] start_m, input int rst_c,
                       output logic [63:0] am, output logic [63:0] bmk,
                       output logic [63:0] dm, output logic [63:0] busym);
        am = '0; bmk = '0; dm = '0; busym = '0;
        @(negedge clk);
        sif.num_txn      = 8'(num);
        sif.delay        = 3'(dly);
        sif.gap          = 4'(gp);
        sif.inject_every = 4'(inj);
        sif.start        = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (sif.a)    am    |= bm(c);
            if (sif.b)    bmk   |= bm(c);
            if (sif.done) dm    |= bm(c);
            if (sif.busy) busym |= bm(c);
            sif.start = start_m[c];
            rst       = (c == rst_c);
        end
        sif.start = 1'b0;
        rst       = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    logic [63:0] am, bmk, dm, busym;

    initial begin
        rst              = 1'b1;
        sif.start        = 1'b0;
        sif.num_txn      = '0;
        sif.delay        = '0;
        sif.gap          = '0;
        sif.inject_every = '0;

        //         num dly gap inj  a cycles                       b cycles                 done txn err
        vt[0] = '{3, 0, 1, 0, bm(1)|bm(3)|bm(5),             bm(1)|bm(3)|bm(5),       7,  3, 0};
        vt[1] = '{2, 2, 0, 0, bm(1)|bm(4),                   bm(3)|bm(6),             7,  2, 0};
        vt[2] = '{4, 1, 0, 2, bm(1)|bm(3)|bm(5)|bm(7),       bm(2)|bm(6),             9,  4, 2};
        vt[3] = '{0, 2, 3, 0, 64'd0,                         64'd0,                   1,  0, 0};
        vt[4] = '{3, 3, 2, 3, bm(1)|bm(7)|bm(13),            bm(4)|bm(10),            19, 3, 1};
        vt[5] = '{5, 0, 0, 1, rng(1, 5),                     64'd0,                   6,  5, 5};
        vt[6] = '{2, 7, 0, 0, bm(1)|bm(9),                   bm(8)|bm(16),            17, 2, 0};

        repeat (3) @(negedge clk);
        chk("rst_a",    64'(sif.a),       64'd0);
        chk("rst_b",    64'(sif.b),       64'd0);
        chk("rst_busy", 64'(sif.busy),    64'd0);
        chk("rst_done", 64'(sif.done),    64'd0);
        chk("rst_txn",  64'(sif.txn_cnt), 64'd0);
        chk("rst_err",  64'(sif.err_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run(vt[i].num, vt[i].dly, vt[i].gap, vt[i].inj, vt[i].done_c + 3, 64'd0, -1,
                am, bmk, dm, busym);
            chk($sformatf("v%0d_a", i),    am,    vt[i].a_m);
            chk($sformatf("v%0d_b", i),    bmk,   vt[i].b_m);
            chk($sformatf("v%0d_done", i), dm,    bm(vt[i].done_c));
            chk($sformatf("v%0d_busy", i), busym, rng(1, vt[i].done_c));
            chk($sformatf("v%0d_txn", i),  64'(sif.txn_cnt), 64'(vt[i].txn));
            chk($sformatf("v%0d_err", i),  64'(sif.err_cnt), 64'(vt[i].err));
        end

        // start pulses in cycles 2 and 7 are ignored; cycle 8 (after DONE) restarts.
        run(3, 0, 1, 0, 18, bm(2)|bm(7)|bm(8), -1, am, bmk, dm, busym);
        chk("ign_a",    am,    bm(1)|bm(3)|bm(5)|bm(9)|bm(11)|bm(13));
        chk("ign_b",    bmk,   bm(1)|bm(3)|bm(5)|bm(9)|bm(11)|bm(13));
        chk("ign_done", dm,    bm(7)|bm(15));
        chk("ign_busy", busym, rng(1, 7)|rng(9, 15));
        chk("ign_txn",  64'(sif.txn_cnt), 64'd3);

        // Reset in cycle 3 of the delay-2 run, with a coincident start that must be ignored.
        run(2, 2, 0, 0, 12, bm(3), 3, am, bmk, dm, busym);
        chk("rab_a",    am,    bm(1));
        chk("rab_b",    bmk,   bm(3));
        chk("rab_done", dm,    64'd0);
        chk("rab_busy", busym, rng(1, 3));
        chk("rab_txn",  64'(sif.txn_cnt), 64'd0);
        chk("rab_err",  64'(sif.err_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/impl_stim_gen.md
# impl_stim_gen

Programmable antecedent/consequent stimulus generator for the SVA implication exercises: drives `a` and `b` so that `b` follows each `a` pulse after a configurable delay. Delay 0 produces overlapped-implication (`a |-> b`) traffic, delay 1 non-overlapped (`a |=> b`), and larger delays produce `##N` traffic. It can deliberately drop consequents so that the checker's fail path is exercised. It sits in the testbench alongside the property checker as the synthesizable source of its stimulus.

## Interface
- `DELAY_W`, default 3: width of `delay`; maximum delay 2^DELAY_W-1.
- `CNT_W`, default 8: width of `num_txn`, `txn_cnt`, `err_cnt`.
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: begin a run; sampled only while `busy`=0.
- `num_txn`  in  CNT_W: transactions per run; latched on start.
- `delay`  in  DELAY_W: cycles from `a` to `b`; latched on start.
- `gap`  in  4: idle cycles after each transaction; latched on start.
- `inject_every`  in  4: 0 = never drop; k = drop `b` on every k-th transaction (1-based); latched on start.
- `a`  out  1: antecedent pulse.
- `b`  out  1: consequent pulse.
- `busy`  out  1: run in progress (state ≠ IDLE).
- `done`  out  1: one-cycle pulse at end of run.
- `txn_cnt`  out  CNT_W: antecedents issued in current/last run.
- `err_cnt`  out  CNT_W: consequents dropped in current/last run.

## Operation
- Moore FSM: IDLE, ANTE, WAIT, CONS, GAP, DONE. `a`, `b`, `busy`, and `done` are decoded from the registered state. They carry no combinational path from the inputs.
- IDLE: `start`=1 latches the config, clears `txn_cnt`/`err_cnt`/the modulo counter, then goes to ANTE, or to DONE if `num_txn`=0.
- ANTE, 1 cycle:
  - `a`=1 and `txn_cnt`+1.
  - If delay=0, `b`=1 in the same cycle unless dropped.
  - Next state: delay=0 → GAP, or the next-transaction decision when gap=0. delay=1 → CONS. delay>1 → WAIT.
- WAIT: `a`=`b`=0 for delay-1 cycles (down-counter), then CONS.
- CONS, 1 cycle: `b`=1 unless dropped. Next: GAP if gap>0, else the next-transaction decision.
- GAP: `a`=`b`=0 for `gap` cycles.
- Next-transaction decision: ANTE if `txn_cnt` < `num_txn`, else DONE.
- DONE, 1 cycle: `done`=1, `busy`=1. Next state IDLE.
- Transaction length is exactly 1+delay+gap cycles. Consecutive transactions never overlap.
- Drop rule:
  - A modulo counter runs 1..inject_every, advancing each ANTE.
  - When it equals `inject_every` (≠0), that transaction's consequent cycle outputs `b`=0, `err_cnt`+1 (counted in the consequent cycle), and the counter wraps to 1.
- Counters hold their values after DONE until the next accepted start. No wrap occurs within a run, since `txn_cnt` ≤ `num_txn`.
- `start` is ignored while `busy`=1, including the DONE cycle.
- `rst` has priority over everything. It forces IDLE and zeroes `a`, `b`, `busy`, `done`, `txn_cnt`, `err_cnt`, and all internal counters on the next edge. Mid-run reset aborts with no `done` pulse.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `txn_cnt`=0, `err_cnt`=0, state IDLE.
- Cycle numbering: cycle 0 is the cycle in which `start`=1 is sampled in IDLE. The first `a` occurs in cycle 1.
- The n-th (1-based) `a` occurs in cycle 1+(n-1)·(1+delay+gap), and its `b` occurs delay cycles later.
- `done` occurs in cycle 1+num_txn·(1+delay+gap). For `num_txn`=0 it occurs in cycle 1.
- Earliest restart: `start` sampled in the cycle after DONE.

## Test plan
- num_txn=3, delay=0, gap=1, inject=0 → `a`=`b`=1 in cycles 1,3,5; `done` in cycle 7; `txn_cnt`=3, `err_cnt`=0.
- num_txn=2, delay=2, gap=0 → `a` in cycles 1,4; `b` in cycles 3,6; `done` in cycle 7; `b` never coincides with `a`.
- num_txn=4, delay=1, gap=0, inject_every=2 → `a` in cycles 1,3,5,7; `b` only in cycles 2,6; `err_cnt`=2; `done` in cycle 9.
- num_txn=0 → `busy`=1 in cycle 1 only, `done` in cycle 1, no `a`/`b`, counts 0.
- `start` pulsed in cycles 2 and 7 of the first scenario → ignored, timing unchanged. `start` in cycle 8 → new run with `a` in cycle 9.
- `rst`=1 in cycle 3 of the second scenario → from cycle 4, `a`=`b`=`busy`=0 and counts 0, no `done`. A `start` sampled together with `rst` is ignored.
